// File: rtl/pwm_pkg.sv
// pwm_pkg -- shared types and constants for the multi-channel PWM block.
//   pwm_mode_e   : edge-aligned / center-aligned counting
//   pwm_dir_e    : counter ramp direction (center mode only)
//   PWM_IDLE_LVL : compare-register level while disabled or in reset
package pwm_pkg;

  typedef enum logic {PWM_EDGE = 1'b0, PWM_CENTER = 1'b1} pwm_mode_e;
  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} pwm_dir_e;

  localparam logic PWM_IDLE_LVL = 1'b0;

endpackage

// File: rtl/pwm_channel.sv
// pwm_channel -- one PWM output: shadowed duty register, compare, output flop.
// Ports:
//   clk, rst        clock, async active-low reset
//   en              run enable; low drives the compare flop to idle
//   load            period boundary (or disabled): active duty takes pending
//   cnt             shared counter value
//   duty_wr         duty write strobe for this channel
//   duty_data       duty value to write
//   polarity        (PWM_POLARITY_EN only) 1 = inverted output
//   pwm_out         registered PWM output
// Macro PWM_POLARITY_EN adds the polarity input.
module pwm_channel #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] cnt,
  input  logic             duty_wr,
  input  logic [CNT_W-1:0] duty_data,
`ifdef PWM_POLARITY_EN
  input  logic             polarity,
`endif
  output logic             pwm_out
);
  import pwm_pkg::*;

  logic [CNT_W-1:0] duty_pend;
  logic [CNT_W-1:0] duty_act;
  logic             cmp_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      duty_pend <= '0;
      duty_act  <= '0;
      cmp_q     <= PWM_IDLE_LVL;
    end else begin
      if (duty_wr) duty_pend <= duty_data;
      // A write landing on the boundary cycle goes straight to the active
      // register so it governs the period that is just starting.
      if (load) duty_act <= duty_wr ? duty_data : duty_pend;
      // Counter never exceeds the active period, so D > P is constant high.
      cmp_q <= en & (cnt < duty_act);
    end
  end

`ifdef PWM_POLARITY_EN
  // Inversion sits after the compare flop so an inverted channel idles high
  // even while the flop itself is held in reset.
  assign pwm_out = cmp_q ^ polarity;
`else
  assign pwm_out = cmp_q;
`endif

endmodule

// File: rtl/pwm_multi_channel.sv
// pwm_multi_channel -- multi-channel PWM generator with a shared counter.
// Edge-aligned (period P+1) or center-aligned (period 2P) counting; period,
// duty and mode are shadowed and only change at a period boundary.
// Ports:
//   clk, rst        clock, async active-low reset
//   en              run enable; low holds counter at 0 and outputs idle
//   mode            requested mode (0 edge, 1 center), sampled every cycle
//   period_wr/data  period write
//   duty_wr[NUM_CH] per-channel duty write strobes, duty_data shared value
//   ch_polarity     (PWM_POLARITY_EN only) per-channel output inversion
//   pwm_out[NUM_CH] registered PWM outputs
//   cycle_start     registered pulse on the first clock of each period
// Macro PWM_POLARITY_EN adds the ch_polarity input.
module pwm_multi_channel #(
  parameter int          NUM_CH     = 4,
  parameter int          CNT_W      = 8,
  parameter int unsigned DEF_PERIOD = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              mode,
  input  logic              period_wr,
  input  logic [CNT_W-1:0]  period_data,
  input  logic [NUM_CH-1:0] duty_wr,
  input  logic [CNT_W-1:0]  duty_data,
`ifdef PWM_POLARITY_EN
  input  logic [NUM_CH-1:0] ch_polarity,
`endif
  output logic [NUM_CH-1:0] pwm_out,
  output logic              cycle_start
);
  import pwm_pkg::*;

  localparam logic [CNT_W-1:0] DEF_P = DEF_PERIOD[CNT_W-1:0];
  localparam logic [CNT_W-1:0] ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_q, cnt_d;
  pwm_dir_e         dir_q, dir_d;
  logic [CNT_W-1:0] per_pend, per_act;
  pwm_mode_e        mode_pend, mode_act;
  logic             load;
  logic             cs_q;

  // Next counter value. Active period/mode are only replaced when the
  // counter returns to 0, so cnt_q never exceeds per_act.
  always_comb begin
    cnt_d = cnt_q;
    dir_d = dir_q;
    if (!en) begin
      cnt_d = '0;
      dir_d = DIR_UP;
    end else if (mode_act == PWM_EDGE) begin
      dir_d = DIR_UP;
      cnt_d = (cnt_q >= per_act) ? '0 : cnt_q + ONE;
    end else if (dir_q == DIR_UP) begin
      if (cnt_q >= per_act) begin
        // Turn around at P; with P <= 1 the down ramp is empty and the
        // next value is already the next period's 0.
        if (per_act <= ONE) begin
          cnt_d = '0;
        end else begin
          cnt_d = per_act - ONE;
          dir_d = DIR_DOWN;
        end
      end else begin
        cnt_d = cnt_q + ONE;
      end
    end else begin
      if (cnt_q <= ONE) begin
        cnt_d = '0;
        dir_d = DIR_UP;
      end else begin
        cnt_d = cnt_q - ONE;
      end
    end
  end

  // Boundary = the edge that moves the counter to 0. While disabled the
  // counter is held at 0, so shadows reload every cycle.
  assign load = (cnt_d == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      dir_q     <= DIR_UP;
      per_pend  <= DEF_P;
      per_act   <= DEF_P;
      mode_pend <= PWM_EDGE;
      mode_act  <= PWM_EDGE;
      cs_q      <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      dir_q     <= dir_d;
      mode_pend <= pwm_mode_e'(mode);
      if (period_wr) per_pend <= period_data;
      if (load) begin
        per_act  <= period_wr ? period_data : per_pend;
        mode_act <= mode_pend;
      end
      // Counter is 0 only on the first clock of a period in either mode.
      cs_q <= en & (cnt_q == '0);
    end
  end

  assign cycle_start = cs_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    pwm_channel #(.CNT_W(CNT_W)) u_ch (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .load      (load),
      .cnt       (cnt_q),
      .duty_wr   (duty_wr[i]),
      .duty_data (duty_data),
`ifdef PWM_POLARITY_EN
      .polarity  (ch_polarity[i]),
`endif
      .pwm_out   (pwm_out[i])
    );
  end

endmodule
